// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction memory port, redirect request, and the
// valid/ready buffer head toward decode.
interface instr_fetch_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] imem_addr_o;
   logic [DATA_WIDTH-1:0] imem_instr_i;
   logic                  redirect_i;
   logic [DATA_WIDTH-1:0] redirect_pc_i;
   logic                  instr_valid_o;
   logic                  instr_ready_i;
   logic [DATA_WIDTH-1:0] instr_o;
   logic [DATA_WIDTH-1:0] pc_o;
   logic                  halted_o;

   modport master (
      output imem_addr_o,
      input  imem_instr_i,
      input  redirect_i,
      input  redirect_pc_i,
      output instr_valid_o,
      input  instr_ready_i,
      output instr_o,
      output pc_o,
      output halted_o
   );

   modport slave (
      input  imem_addr_o,
      output imem_instr_i,
      output redirect_i,
      output redirect_pc_i,
      input  instr_valid_o,
      output instr_ready_i,
      input  instr_o,
      input  pc_o,
      input  halted_o
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register feeding a small in-order buffer of {pc, instr}
// entries, with redirect flush and halt on EBREAK.
module instr_fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [DATA_WIDTH-1:0] EBREAK  = DATA_WIDTH'(32'h0010_0073);
   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_HALT  = 1'b1;

   logic [0:0]            state_reg;
   logic [DATA_WIDTH-1:0] pc_reg;
   logic [CW-1:0]         count_reg;
   logic [PW-1:0]         rd_ptr_reg;
   logic [PW-1:0]         wr_ptr_reg;
   logic [DATA_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];

   logic                  pop;
   logic                  enq;
   logic [DATA_WIDTH-1:0] redirect_target;

   assign bus.imem_addr_o   = pc_reg;
   assign bus.instr_valid_o = (count_reg != '0);
   assign bus.instr_o       = instr_mem[rd_ptr_reg];
   assign bus.pc_o          = pc_mem[rd_ptr_reg];
   assign bus.halted_o      = (state_reg == ST_HALT);

   // Redirect wins over everything: a same-cycle handshake is not a consume.
   assign pop = bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i;
   assign enq = (state_reg == ST_FETCH) && ((count_reg < DEPTH_C) || pop)
                && !bus.redirect_i;
   assign redirect_target = {bus.redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_FETCH;
         pc_reg     <= RESET_PC;
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
      end else if (bus.redirect_i) begin
         state_reg  <= ST_FETCH;
         pc_reg     <= redirect_target;
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
      end else begin
         count_reg <= count_reg + CW'(enq) - CW'(pop);
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         if (enq) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
            pc_reg     <= pc_reg + DATA_WIDTH'(4);
            if (bus.imem_instr_i == EBREAK) begin
               state_reg <= ST_HALT;
            end
         end
      end
   end

   // Entries are cleared on reset so the head reads zero while empty after reset.
   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pc_mem[gi]    <= '0;
               instr_mem[gi] <= '0;
            end else if (enq && (wr_ptr_reg == PW'(gi))) begin
               pc_mem[gi]    <= pc_reg;
               instr_mem[gi] <= bus.imem_instr_i;
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected deliveries are queued by the stimulus
// and a monitor compares them against every handshake in order.
module tb_instr_fetch;
   logic clk;
   logic rst_n;

   instr_fetch_if #(.DATA_WIDTH(32)) bus ();

   instr_fetch #(
      .DATA_WIDTH(32),
      .RESET_PC  (32'h0000_0000),
      .FIFO_DEPTH(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [256];
   assign bus.imem_instr_i = mem[bus.imem_addr_o[9:2]];

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return mem[addr[9:2]];
   endfunction

   int vectors;
   int miscompares;
   logic [31:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      exp_q.push_back(pc);
   endtask

   task automatic drain_check(input string name);
      chk(name, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   // Monitor: every accepted head entry must match the next queued pc and its memory word.
   always @(negedge clk) begin
      if (rst_n && bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_pc", bus.pc_o, 32'hxxxx_xxxx);
         end else begin
            logic [31:0] epc;
            epc = exp_q.pop_front();
            chk("sb_pc", bus.pc_o, epc);
            chk("sb_instr", bus.instr_o, mem_word(epc));
            $display("deliver pc=%h instr=%h", bus.pc_o, bus.instr_o);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0A00_0000 | (i << 2);
      mem[0]              = 32'h0010_0093;
      mem[1]              = 32'h0020_0113;
      mem[32'hE4 >> 2]    = 32'h0010_0073;
      rst_n = 1'b0;
      bus.instr_ready_i = 1'b0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;
      #1;
      chk("rst_valid", bus.instr_valid_o, 0);
      chk("rst_halted", bus.halted_o, 0);
      chk("rst_addr", bus.imem_addr_o, 32'h0);
      chk("rst_instr", bus.instr_o, 32'h0);
      chk("rst_pc", bus.pc_o, 32'h0);
      step();
      step();
      chk("rst_hold_addr", bus.imem_addr_o, 32'h0);
      chk("rst_hold_valid", bus.instr_valid_o, 0);

      // Streaming after reset release with decode always ready
      expect_pc(32'h0);
      expect_pc(32'h4);
      bus.instr_ready_i = 1'b1;
      rst_n = 1'b1;
      chk("first_latency_valid", bus.instr_valid_o, 0);
      step();
      chk("c1_valid", bus.instr_valid_o, 1);
      chk("c1_instr", bus.instr_o, 32'h0010_0093);
      chk("c1_pc", bus.pc_o, 32'h0);
      step();
      chk("c2_instr", bus.instr_o, 32'h0020_0113);
      chk("c2_pc", bus.pc_o, 32'h4);
      step();
      bus.instr_ready_i = 1'b0;
      drain_check("stream_left");

      // Two entries buffered, then async reset pulse between edges
      step();
      chk("prepulse_pc", bus.pc_o, 32'h8);
      chk("prepulse_addr", bus.imem_addr_o, 32'h10);
      #2 rst_n = 1'b0;
      #1;
      chk("pulse_valid", bus.instr_valid_o, 0);
      chk("pulse_addr", bus.imem_addr_o, 32'h0);
      chk("pulse_pc", bus.pc_o, 32'h0);
      rst_n = 1'b1;

      // Backpressure: buffer saturates, then drains in order without gaps
      repeat (5) step();
      chk("sat_valid", bus.instr_valid_o, 1);
      chk("sat_addr", bus.imem_addr_o, 32'h8);
      chk("sat_pc", bus.pc_o, 32'h0);
      expect_pc(32'h0);
      expect_pc(32'h4);
      expect_pc(32'h8);
      bus.instr_ready_i = 1'b1;
      repeat (3) step();
      bus.instr_ready_i = 1'b0;
      drain_check("sat_left");

      // Full buffer, redirect with a same-cycle handshake
      step();
      chk("full_addr", bus.imem_addr_o, 32'h14);
      chk("full_pc", bus.pc_o, 32'hC);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'hC4;
      bus.instr_ready_i = 1'b1;
      step();
      bus.redirect_i = 1'b0;
      chk("redir_valid", bus.instr_valid_o, 0);
      chk("redir_addr", bus.imem_addr_o, 32'hC4);
      expect_pc(32'hC4);
      step();
      chk("redir_next_valid", bus.instr_valid_o, 1);
      chk("redir_next_pc", bus.pc_o, 32'hC4);
      step();
      bus.instr_ready_i = 1'b0;
      drain_check("redir_left");

      // Unaligned redirect target is forced to word alignment
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'hDE;
      step();
      bus.redirect_i = 1'b0;
      chk("align_addr", bus.imem_addr_o, 32'hDC);
      chk("align_valid", bus.instr_valid_o, 0);
      step();
      chk("align_pc", bus.pc_o, 32'hDC);
      expect_pc(32'hDC);
      bus.instr_ready_i = 1'b1;
      step();
      bus.instr_ready_i = 1'b0;
      drain_check("align_left");

      // EBREAK at 0xE4 halts fetch; buffered entries still drain
      step();
      chk("ebrk_halted", bus.halted_o, 1);
      chk("ebrk_addr", bus.imem_addr_o, 32'hE8);
      step();
      chk("halt_hold_addr", bus.imem_addr_o, 32'hE8);
      expect_pc(32'hE0);
      expect_pc(32'hE4);
      bus.instr_ready_i = 1'b1;
      step();
      chk("halt_drain_valid", bus.instr_valid_o, 1);
      chk("halt_drain_pc", bus.pc_o, 32'hE4);
      step();
      chk("halt_empty_valid", bus.instr_valid_o, 0);
      chk("halt_empty_addr", bus.imem_addr_o, 32'hE8);
      chk("halt_still", bus.halted_o, 1);
      bus.instr_ready_i = 1'b0;
      drain_check("halt_left");

      // Redirect out of HALT to the top of the address space to see PC wrap
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'hFFFF_FFFC;
      step();
      bus.redirect_i = 1'b0;
      chk("unhalt", bus.halted_o, 0);
      chk("wrap_start", bus.imem_addr_o, 32'hFFFF_FFFC);
      step();
      chk("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);
      chk("wrap_addr", bus.imem_addr_o, 32'h0);

      // Redirect to 0 resumes fetch there
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h0;
      step();
      bus.redirect_i = 1'b0;
      chk("resume_addr", bus.imem_addr_o, 32'h0);
      step();
      chk("resume_pc", bus.pc_o, 32'h0);
      chk("resume_instr", bus.instr_o, 32'h0010_0093);
      drain_check("final_left");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the address and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, giving the number of fetch buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imem_addr_o  output  DATA_WIDTH  byte address presented to the instruction memory.
REQ-007 SHALL have port imem_instr_i  input  DATA_WIDTH  instruction word returned combinationally for imem_addr_o in the same cycle.
REQ-008 SHALL have port redirect_i  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc_i  input  DATA_WIDTH  redirect target byte address.
REQ-010 SHALL have port instr_valid_o  output  1  head buffer entry is valid toward decode.
REQ-011 SHALL have port instr_ready_i  input  1  decode accepts the head entry.
REQ-012 SHALL have port instr_o  output  DATA_WIDTH  instruction at the buffer head.
REQ-013 SHALL have port pc_o  output  DATA_WIDTH  byte address of instr_o.
REQ-014 SHALL have port halted_o  output  1  fetch stopped after an EBREAK.

Function
REQ-015 SHALL keep a PC register; imem_addr_o SHALL equal the PC register at all times.
REQ-016 SHALL implement a two-state FSM: FETCH and HALT; halted_o SHALL be 1 only in HALT.
REQ-017 In FETCH, enqueue {PC, imem_instr_i} at the clock edge when the buffer count < FIFO_DEPTH or a pop occurs in the same cycle; on enqueue, PC += 4.
REQ-018 PC increment SHALL wrap modulo 2^DATA_WIDTH (32'hFFFF_FFFC + 4 = 32'h0).
REQ-019 Pop SHALL occur when instr_valid_o and instr_ready_i are both 1; entries SHALL leave in enqueue order.
REQ-020 instr_valid_o SHALL be 1 if and only if the buffer count is nonzero; instr_o/pc_o SHALL be the head entry and remain stable while valid and not popped.
REQ-021 Simultaneous enqueue and pop on a full buffer SHALL keep the count unchanged and lose no entry.
REQ-022 Enqueuing the word 32'h0010_0073 (EBREAK) SHALL move the FSM to HALT; the EBREAK entry itself is delivered; PC SHALL hold at EBREAK address + 4.
REQ-023 In HALT, no enqueue SHALL occur; pops continue until empty.
REQ-024 redirect_i=1 SHALL, at that edge, flush all buffer entries, load PC with {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}, and set the FSM to FETCH.
REQ-025 Redirect SHALL take priority over enqueue and pop in the same cycle: no entry is enqueued, and a same-cycle handshake is discarded (not treated as consumed).
REQ-026 First post-redirect entry SHALL be valid one cycle after the redirect edge.
REQ-027 Latency: imem_addr_o to instr_valid_o SHALL be exactly one clock edge when the buffer is empty.

Reset
REQ-028 While rst_n=0: PC = RESET_PC, buffer count = 0, FSM = FETCH, instr_valid_o = 0, halted_o = 0, instr_o = 0, pc_o = 0.
REQ-029 Reset assertion mid-operation SHALL take effect immediately without a clock, discarding all buffered entries.
REQ-030 First enqueue SHALL occur at the first rising edge after rst_n deasserts.

Verification
REQ-031 Reset release, ready=1, mem[0]=32'h0010_0093, mem[4]=32'h0020_0113 -> cycle 1: valid=1, instr_o=32'h0010_0093, pc_o=0; cycle 2: instr_o=32'h0020_0113, pc_o=4.
REQ-032 ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr_o holds 32'h8, head pc_o=0; ready=1 -> pc_o 0, 4, 8 in consecutive cycles, no gaps or duplicates.
REQ-033 Buffer full, redirect_i=1 with redirect_pc_i=32'hC4 and ready=1 in the same cycle -> next cycle valid=0, imem_addr_o=32'hC4; following cycle pc_o=32'hC4.
REQ-034 redirect_pc_i=32'hDE -> imem_addr_o=32'hDC, next entry pc_o=32'hDC.
REQ-035 mem[32'hE4]=32'h0010_0073 -> entry pc_o=32'hE4 delivered, halted_o=1, imem_addr_o holds 32'hE8, valid falls after the pop; redirect to 32'h0 -> halted_o=0, fetch resumes at 0.
REQ-036 rst_n pulsed low between clock edges with 2 entries buffered -> instr_valid_o=0 and imem_addr_o=RESET_PC immediately, before the next edge.
